// File: rtl/seq_detector_1011.sv
// rtl/seq_detector_1011.sv - serial pattern detector with registered match flag and saturating match counter
// Only the PATTERN_LEN-1 most recent prior bits are stored; the oldest bit would fall off on the next shift anyway.
module seq_detector_1011 #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] det_count
);

  localparam int                FILL_W = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PATTERN_LEN);

  logic [PATTERN_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   z_q, z_d;
  logic [CNT_W-1:0]       det_count_q, det_count_d;

  logic [PATTERN_LEN-1:0] hist_next;
  logic [FILL_W-1:0]      fill_next;
  logic                   match;

  always_comb begin
    hist_next   = {hist_q, x};
    fill_next   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    // Requiring a full history blocks false hits right after reset, even for an all-zero pattern.
    match       = (fill_next == FULL) && (hist_next == PATTERN);

    hist_d      = hist_next[PATTERN_LEN-2:0];
    fill_d      = (match && !OVERLAP) ? '0 : fill_next;
    z_d         = match;
    det_count_d = det_count_q;
    if (match && (det_count_q != {CNT_W{1'b1}})) begin
      det_count_d = det_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q      <= '0;
      fill_q      <= '0;
      z_q         <= 1'b0;
      det_count_q <= '0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      z_q         <= z_d;
      det_count_q <= det_count_d;
    end
  end

  assign z         = z_q;
  assign det_count = det_count_q;

endmodule

// File: tb/tb_seq_detector_1011.sv
// tb/tb_seq_detector_1011.sv - scoreboard bench for seq_detector_1011 across four parameterisations
// 0: default 1011 overlap, 1: 1011 no overlap, 2: pattern 0000, 3: pattern 1111 with 2-bit counter.
module tb_seq_detector_1011;

  typedef struct {
    logic z;
    int   cnt;
  } exp_t;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] x_v;
  logic [3:0] z_v;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;

  exp_t q[4][$];
  int   checks;
  int   passed;

  seq_detector_1011 u_a (
    .clk(clk), .reset(rst_v[0]), .x(x_v[0]), .z(z_v[0]), .det_count(cnt_a)
  );
  seq_detector_1011 #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .reset(rst_v[1]), .x(x_v[1]), .z(z_v[1]), .det_count(cnt_b)
  );
  seq_detector_1011 #(.PATTERN(4'b0000)) u_c (
    .clk(clk), .reset(rst_v[2]), .x(x_v[2]), .z(z_v[2]), .det_count(cnt_c)
  );
  seq_detector_1011 #(.PATTERN(4'b1111), .CNT_W(2)) u_d (
    .clk(clk), .reset(rst_v[3]), .x(x_v[3]), .z(z_v[3]), .det_count(cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cnt_of(input int k);
    case (k)
      0:       cnt_of = int'(cnt_a);
      1:       cnt_of = int'(cnt_b);
      2:       cnt_of = int'(cnt_c);
      default: cnt_of = int'(cnt_d);
    endcase
  endfunction

  // Monitor: one expected entry is pushed per clock edge, compared on the following falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() > 0) begin
        exp_t e;
        e = q[k].pop_front();
        checks++;
        if (z_v[k] === e.z && cnt_of(k) == e.cnt) begin
          passed++;
        end else begin
          $display("FAIL inst%0d check%0d: z=%0b det_count=%0d, expected z=%0b det_count=%0d",
                   k, checks, z_v[k], cnt_of(k), e.z, e.cnt);
        end
      end
    end
  end

  task automatic do_step(input int id, input logic rst, input logic xb, input logic ez, input int ecnt);
    exp_t e;
    rst_v[id] = rst;
    x_v[id]   = xb;
    @(posedge clk);
    e.z   = ez;
    e.cnt = ecnt;
    q[id].push_back(e);
    #1;
  endtask

  // One reset edge (sampling rst_x, which must be discarded), then the bit string with its hand-computed z mask.
  task automatic run(input int id, input string bits, input string zm, input int cmax, input logic rst_x);
    int c;
    c = 0;
    do_step(id, 1'b1, rst_x, 1'b0, 0);
    for (int i = 0; i < bits.len(); i++) begin
      logic b, ez;
      b  = (bits[i] == "1");
      ez = (zm[i] == "1");
      if (ez && c < cmax) c++;
      do_step(id, 1'b0, b, ez, c);
    end
  endtask

  initial begin
    int guard;
    checks = 0;
    passed = 0;
    rst_v  = 4'hF;
    x_v    = 4'h0;
    repeat (2) @(posedge clk);
    #1;

    run(0, "00101100011001110", "00000100000000000", 255, 1'b0);
    run(0, "1011011", "0001001", 255, 1'b0);
    run(1, "1011011", "0001000", 255, 1'b0);
    run(0, "101", "000", 255, 1'b0);
    run(0, "1011", "0001", 255, 1'b1);
    run(0, "011", "000", 255, 1'b1);
    run(2, "00000000", "00011111", 255, 1'b0);
    run(3, "1111111", "0001111", 3, 1'b0);
    run(1, "10110111011", "00010000001", 255, 1'b1);

    guard = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0",
               q[0].size() + q[1].size() + q[2].size() + q[3].size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
